shiftreg_arbiter: RTL and testbench
===================================

SHIFTREG_ARBITER -- requirements
Module: shiftreg_arbiter

Interface
REQ-001 Parameter WDOG_CYCLES, default 255: maximum cycles a transfer may wait for the driver before it is aborted; the legal range is 2..65535.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous, active-high.
REQ-004 i_Req  input  4  per-requester request level; bit k belongs to requester k.
REQ-005 i_Data  input  32  requester k's byte sits in bits [8k+7:8k].
REQ-006 o_Ack  output  4  one-cycle pulse: requester k's byte was accepted.
REQ-007 o_Done  output  4  one-cycle pulse: requester k's transfer finished, latched or aborted.
REQ-008 o_Busy  output  1  high while a transfer is in progress.
REQ-009 o_Timeout  output  1  one-cycle pulse when the watchdog aborts a transfer.
REQ-010 o_SR_Data  output  8  byte presented to the 74hc595 driver.
REQ-011 o_SR_Enable  output  1  start strobe to the driver.
REQ-012 i_SR_Ready  input  1  driver idle indication.

Function
REQ-013 The state machine SHALL have the states IDLE, ISSUE, WAIT_BUSY, WAIT_READY and DONE.
REQ-014 IDLE SHALL proceed when any i_Req bit is high and i_SR_Ready=1 in the same cycle T.
  - Winner w is chosen in cycle T.
  - i_Data[8w+7:8w] is captured into o_SR_Data.
  - The state moves to ISSUE.
REQ-015 In ISSUE (cycle T+1), the block SHALL drive o_SR_Enable=1 and o_Ack[w]=1 for exactly one cycle, then move to WAIT_BUSY.
REQ-016 WAIT_BUSY SHALL wait for i_SR_Ready=0, then move to WAIT_READY.
REQ-017 WAIT_READY SHALL wait for i_SR_Ready=1, then move to DONE.
REQ-018 DONE SHALL pulse o_Done[w] for one cycle and return to IDLE.
  - A new grant is therefore possible no earlier than the cycle after DONE.
REQ-019 o_SR_Data SHALL hold its value from the capture cycle until the next grant.
REQ-020 Default arbitration SHALL be round-robin.
  - The search starts at the index after the last winner and wraps from 3 to 0.
  - After reset the last-winner pointer is 3, so requester 0 has first priority.
REQ-021 A requester SHALL hold i_Req until it sees o_Ack.
  - A request dropped before grant is not served.
  - i_Req is ignored outside IDLE.
  - A request held high after Ack is treated as a new request.
REQ-022 o_Busy SHALL be high in every state except IDLE.
REQ-023 The watchdog counter SHALL clear on entry to WAIT_BUSY and increment once per cycle in WAIT_BUSY and WAIT_READY; it is 16 bits wide and saturates.
REQ-024 When the counter reaches WDOG_CYCLES, the block SHALL:
  - pulse o_Timeout and o_Done[w] together;
  - not pulse o_Done[w] a second time;
  - go to IDLE, skipping DONE.
REQ-025 The next grant SHALL still require i_SR_Ready=1.
  - A hung driver therefore blocks new grants.
  - No further timeouts fire while in IDLE.
REQ-026 At most one bit of o_Ack and at most one bit of o_Done SHALL be high in any cycle.

Reset
REQ-027 While i_rst=1 on a clock edge, the block SHALL set:
  - state to IDLE and the last-winner pointer to 3;
  - o_SR_Data to 0x00 and the watchdog counter to 0;
  - o_SR_Enable, o_Ack, o_Done, o_Busy and o_Timeout to 0.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer without an o_Done pulse.
  - The driver has no reset, so the next grant waits for i_SR_Ready=1 per REQ-014.

Configuration
REQ-029 With SHIFTREG_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed-priority: the lowest requester index wins and the pointer is unused.
  - Without the macro, round-robin per REQ-020 applies.

Verification
REQ-030 After reset, i_Req=4'b0001 with byte 0xA5 and a driver model SHALL produce the following, with o_Done=0001 and o_Busy low after DONE:
  - o_SR_Enable pulse with o_SR_Data=0xA5;
  - o_Ack=0001 at T+1;
  - o_SR_Data serialized MSB-first as 10100101 on the model.
REQ-031 i_Req=4'b1111 held continuously SHALL grant in the order 0,1,2,3,0, with exactly one Ack per transfer.
REQ-032 With SHIFTREG_ARB_FIXED_PRIO_EN defined and i_Req=4'b0110 held, the bench SHALL see only requester 1 granted, on every grant.
REQ-033 With the driver model stuck at i_SR_Ready=0 after the strobe and WDOG_CYCLES=8, the bench SHALL see:
  - o_Timeout and o_Done pulse 8 cycles after WAIT_BUSY entry;
  - the block back in IDLE;
  - no new grant until Ready=1.
REQ-034 i_rst pulsed during WAIT_READY SHALL give all outputs 0 the next cycle and no o_Done.
  - With i_Req=0010 pending, the next grant goes to requester 1 only after i_SR_Ready=1.
REQ-035 i_Req=0100 raised while the block is in WAIT_READY SHALL give no o_Ack until the cycle after DONE plus one.

Source files
------------

// File: rtl/shiftreg_arbiter.sv
// rtl/shiftreg_arbiter.sv - four-requester arbiter feeding single bytes to a 74hc595 shift-register driver
// Define SHIFTREG_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration; default build is round-robin.
`timescale 1ns/1ps
module shiftreg_arbiter #(
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_Req,
  input  logic [31:0] i_Data,
  output logic [3:0]  o_Ack,
  output logic [3:0]  o_Done,
  output logic        o_Busy,
  output logic        o_Timeout,
  output logic [7:0]  o_SR_Data,
  output logic        o_SR_Enable,
  input  logic        i_SR_Ready
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_BUSY  = 3'd2,
    WAIT_READY = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t      state_q;
  logic [1:0]  winner_q;
  logic [15:0] wdog_q;
  logic [3:0]  ack_q;
  logic [3:0]  done_q;
  logic        busy_q;
  logic        timeout_q;
  logic        enable_q;
  logic [7:0]  data_q;

  logic [1:0]  winner_d;
  logic        grant_d;
  logic [15:0] wdog_d;
  logic        wdog_hit_d;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

`ifdef SHIFTREG_ARB_FIXED_PRIO_EN
  always_comb begin
    winner_d = 2'd0;
    grant_d  = |i_Req;
    for (int k = 3; k >= 0; k--) begin
      if (i_Req[k]) winner_d = 2'(k);
    end
  end
`else
  logic [1:0] last_q;
  logic [1:0] rr_idx;

  // Walk from the farthest candidate to the nearest so the slot right after
  // the previous winner is the last assignment and therefore wins.
  always_comb begin
    winner_d = 2'd0;
    grant_d  = 1'b0;
    rr_idx   = last_q;
    for (int k = 4; k >= 1; k--) begin
      rr_idx = last_q + 2'(k);
      if (i_Req[rr_idx]) begin
        winner_d = rr_idx;
        grant_d  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    wdog_d     = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
    wdog_hit_d = ({16'd0, wdog_d} >= WDOG_CYCLES);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      winner_q  <= 2'd0;
      wdog_q    <= 16'd0;
      ack_q     <= 4'd0;
      done_q    <= 4'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      enable_q  <= 1'b0;
      data_q    <= 8'h00;
`ifndef SHIFTREG_ARB_FIXED_PRIO_EN
      last_q    <= 2'd3;
`endif
    end else begin
      ack_q     <= 4'd0;
      done_q    <= 4'd0;
      timeout_q <= 1'b0;
      enable_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d && i_SR_Ready) begin
            winner_q <= winner_d;
            data_q   <= i_Data[{winner_d, 3'b000} +: 8];
            enable_q <= 1'b1;
            ack_q    <= onehot(winner_d);
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
`ifndef SHIFTREG_ARB_FIXED_PRIO_EN
            last_q   <= winner_d;
`endif
          end
        end
        ISSUE: begin
          wdog_q  <= 16'd0;
          state_q <= WAIT_BUSY;
        end
        // Driver progress takes precedence over a watchdog expiring the same cycle.
        WAIT_BUSY: begin
          wdog_q <= wdog_d;
          if (!i_SR_Ready) begin
            state_q <= WAIT_READY;
          end else if (wdog_hit_d) begin
            timeout_q <= 1'b1;
            done_q    <= onehot(winner_q);
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        WAIT_READY: begin
          wdog_q <= wdog_d;
          if (i_SR_Ready) begin
            done_q  <= onehot(winner_q);
            state_q <= DONE;
          end else if (wdog_hit_d) begin
            timeout_q <= 1'b1;
            done_q    <= onehot(winner_q);
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ($onehot0(ack_q));
      assert ($onehot0(done_q));
    end
  end

  assign o_Ack       = ack_q;
  assign o_Done      = done_q;
  assign o_Busy      = busy_q;
  assign o_Timeout   = timeout_q;
  assign o_SR_Data   = data_q;
  assign o_SR_Enable = enable_q;

endmodule

// File: tb/tb_shiftreg_arbiter.sv
// tb/tb_shiftreg_arbiter.sv - directed bench for shiftreg_arbiter with a serialising 74hc595 driver model
`timescale 1ns/1ps
module tb_shiftreg_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  ack_a, done_a, ack_b, done_b;
  logic        busy_a, busy_b, to_a, to_b, en_a, en_b;
  logic [7:0]  srd_a, srd_b;
  logic        rdy_a = 1'b1;
  logic        rdy_b;

  logic [3:0]  drv_cnt = 4'd0;
  logic [7:0]  drv_shift = 8'd0;
  logic [7:0]  drv_cap = 8'd0;

  int n_checks = 0;
  int n_fail = 0;

  shiftreg_arbiter dut_a (
    .i_clk(clk), .i_rst(rst), .i_Req(req_a), .i_Data(data_a),
    .o_Ack(ack_a), .o_Done(done_a), .o_Busy(busy_a), .o_Timeout(to_a),
    .o_SR_Data(srd_a), .o_SR_Enable(en_a), .i_SR_Ready(rdy_a)
  );

  shiftreg_arbiter #(.WDOG_CYCLES(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_Req(req_b), .i_Data(data_b),
    .o_Ack(ack_b), .o_Done(done_b), .o_Busy(busy_b), .o_Timeout(to_b),
    .o_SR_Data(srd_b), .o_SR_Enable(en_b), .i_SR_Ready(rdy_b)
  );

  // 74hc595 driver: one bit per clock, MSB first, busy for eight clocks.
  always @(posedge clk) begin
    if (drv_cnt != 4'd0) begin
      drv_cap   <= {drv_cap[6:0], drv_shift[7]};
      drv_shift <= {drv_shift[6:0], 1'b0};
      drv_cnt   <= drv_cnt - 4'd1;
      if (drv_cnt == 4'd1) rdy_a <= 1'b1;
    end else if (en_a && rdy_a) begin
      drv_shift <= srd_a;
      drv_cap   <= 8'd0;
      drv_cnt   <= 4'd8;
      rdy_a     <= 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 4'd0; req_b = 4'd0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_idle_a(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!busy_a && rdy_a) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    n_checks++; if ({ack_a, done_a, busy_a, to_a, en_a} !== 11'd0) begin n_fail++; $display("FAIL reset_ctrl_a got=%b want=0", {ack_a, done_a, busy_a, to_a, en_a}); end
    n_checks++; if (srd_a !== 8'h00) begin n_fail++; $display("FAIL reset_data_a got=%h want=00", srd_a); end
    n_checks++; if ({ack_b, done_b, busy_b, to_b, en_b} !== 11'd0) begin n_fail++; $display("FAIL reset_ctrl_b got=%b want=0", {ack_b, done_b, busy_b, to_b, en_b}); end
    n_checks++; if (srd_b !== 8'h00) begin n_fail++; $display("FAIL reset_data_b got=%h want=00", srd_b); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single();
    int k;
    bit ok;
    req_a = 4'b0001; data_a = 32'hC3965AA5;
    step(1);
    n_checks++; if (en_a !== 1'b1) begin n_fail++; $display("FAIL single_enable got=%b want=1", en_a); end
    n_checks++; if (ack_a !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b want=0001", ack_a); end
    n_checks++; if (srd_a !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h want=a5", srd_a); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b want=1", busy_a); end
    req_a = 4'd0;
    step(1);
    n_checks++; if ({en_a, ack_a} !== 5'd0) begin n_fail++; $display("FAIL single_pulse_len got=%b want=00000", {en_a, ack_a}); end
    for (k = 0; k < 30; k++) begin
      if (done_a != 4'd0) break;
      step(1);
    end
    n_checks++; if (k != 9) begin n_fail++; $display("FAIL single_done_latency got=%0d want=9", k); end
    n_checks++; if (done_a !== 4'b0001) begin n_fail++; $display("FAIL single_done got=%b want=0001", done_a); end
    n_checks++; if (drv_cap !== 8'b10100101) begin n_fail++; $display("FAIL single_serial got=%b want=10100101", drv_cap); end
    n_checks++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL single_no_timeout got=%b want=0", to_a); end
    step(1);
    n_checks++; if ({done_a, busy_a} !== 5'd0) begin n_fail++; $display("FAIL single_idle got=%b want=00000", {done_a, busy_a}); end
    wait_idle_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_settle got=busy want=idle"); end
  endtask

  task automatic test_round_robin();
    int k;
    bit ok;
    logic [3:0] exp_ack [5];
    logic [7:0] exp_byte [5];
`ifdef SHIFTREG_ARB_FIXED_PRIO_EN
    exp_ack  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_byte = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
    exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_byte = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`endif
    do_reset();
    req_a = 4'b1111; data_a = 32'h44332211;
    for (int t = 0; t < 5; t++) begin
      for (k = 0; k < 20; k++) begin
        if (ack_a != 4'd0) break;
        step(1);
      end
      n_checks++; if (ack_a !== exp_ack[t]) begin n_fail++; $display("FAIL rr_ack%0d got=%b want=%b", t, ack_a, exp_ack[t]); end
      n_checks++; if (srd_a !== exp_byte[t]) begin n_fail++; $display("FAIL rr_data%0d got=%h want=%h", t, srd_a, exp_byte[t]); end
      step(1);
      n_checks++; if (ack_a !== 4'd0) begin n_fail++; $display("FAIL rr_single_ack%0d got=%b want=0000", t, ack_a); end
    end
    req_a = 4'd0;
    wait_idle_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_settle got=busy want=idle"); end
  endtask

  task automatic test_pair_0110();
    int k;
    bit ok;
    logic [3:0] exp_ack [3];
`ifdef SHIFTREG_ARB_FIXED_PRIO_EN
    exp_ack = '{4'b0010, 4'b0010, 4'b0010};
`else
    exp_ack = '{4'b0010, 4'b0100, 4'b0010};
`endif
    do_reset();
    req_a = 4'b0110; data_a = 32'h77665544;
    for (int t = 0; t < 3; t++) begin
      for (k = 0; k < 20; k++) begin
        if (ack_a != 4'd0) break;
        step(1);
      end
      n_checks++; if (ack_a !== exp_ack[t]) begin n_fail++; $display("FAIL pair_ack%0d got=%b want=%b", t, ack_a, exp_ack[t]); end
      step(1);
    end
    req_a = 4'd0;
    wait_idle_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pair_settle got=busy want=idle"); end
  endtask

  task automatic test_timeout();
    int k;
    int seen;
    do_reset();
    rdy_b = 1'b1; req_b = 4'b1000; data_b = 32'h5C000000;
    step(1);
    n_checks++; if ({ack_b, en_b} !== 5'b10001) begin n_fail++; $display("FAIL wd_grant got=%b want=10001", {ack_b, en_b}); end
    n_checks++; if (srd_b !== 8'h5C) begin n_fail++; $display("FAIL wd_data got=%h want=5c", srd_b); end
    req_b = 4'd0; rdy_b = 1'b0;
    for (k = 0; k < 20; k++) begin
      step(1);
      if (to_b) break;
    end
    n_checks++; if (k != 8) begin n_fail++; $display("FAIL wd_latency got=%0d want=8", k); end
    n_checks++; if (done_b !== 4'b1000) begin n_fail++; $display("FAIL wd_done got=%b want=1000", done_b); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL wd_idle got=%b want=0", busy_b); end
    step(1);
    n_checks++; if ({to_b, done_b} !== 5'd0) begin n_fail++; $display("FAIL wd_single_pulse got=%b want=00000", {to_b, done_b}); end
    req_b = 4'b0001; data_b = 32'h000000E2;
    seen = 0;
    repeat (20) begin
      step(1);
      if (ack_b != 4'd0 || to_b || busy_b || done_b != 4'd0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL wd_hung_block got=%0d want=0", seen); end
    rdy_b = 1'b1;
    step(1);
    n_checks++; if (ack_b !== 4'b0001) begin n_fail++; $display("FAIL wd_regrant got=%b want=0001", ack_b); end
    req_b = 4'd0; rdy_b = 1'b0;
    step(2);
    rdy_b = 1'b1;
    for (k = 0; k < 10; k++) begin
      step(1);
      if (done_b != 4'd0) break;
    end
    n_checks++; if ({done_b, to_b} !== 5'b00010) begin n_fail++; $display("FAIL wd_normal_done got=%b want=00010", {done_b, to_b}); end
    step(2);
  endtask

  task automatic test_reset_mid();
    int k;
    int dn;
    bit ok;
    do_reset();
    req_a = 4'b0001; data_a = 32'h0000813C;
    step(1);
    n_checks++; if (ack_a !== 4'b0001) begin n_fail++; $display("FAIL mid_ack got=%b want=0001", ack_a); end
    req_a = 4'b0010;
    step(3);
    rst = 1'b1;
    step(1);
    n_checks++; if ({ack_a, done_a, busy_a, to_a, en_a} !== 11'd0) begin n_fail++; $display("FAIL mid_reset_ctrl got=%b want=0", {ack_a, done_a, busy_a, to_a, en_a}); end
    n_checks++; if (srd_a !== 8'h00) begin n_fail++; $display("FAIL mid_reset_data got=%h want=00", srd_a); end
    rst = 1'b0;
    dn = 0;
    for (k = 0; k < 20; k++) begin
      if (ack_a != 4'd0) break;
      if (done_a != 4'd0) dn++;
      step(1);
    end
    n_checks++; if (k != 6) begin n_fail++; $display("FAIL mid_wait_ready got=%0d want=6", k); end
    n_checks++; if (ack_a !== 4'b0010) begin n_fail++; $display("FAIL mid_regrant got=%b want=0010", ack_a); end
    n_checks++; if (srd_a !== 8'h81) begin n_fail++; $display("FAIL mid_data got=%h want=81", srd_a); end
    n_checks++; if (dn != 0) begin n_fail++; $display("FAIL mid_no_done got=%0d want=0", dn); end
    req_a = 4'd0;
    wait_idle_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_settle got=busy want=idle"); end
  endtask

  task automatic test_late_req();
    int k;
    int dseen;
    bit ok;
    req_a = 4'b0001; data_a = 32'h00E70019;
    step(1);
    n_checks++; if (ack_a !== 4'b0001) begin n_fail++; $display("FAIL late_first_ack got=%b want=0001", ack_a); end
    req_a = 4'd0;
    step(2);
    req_a = 4'b0100;
    dseen = -1;
    for (k = 0; k < 20; k++) begin
      if (ack_a != 4'd0) break;
      if (done_a != 4'd0) dseen = k;
      step(1);
    end
    n_checks++; if (dseen != 8) begin n_fail++; $display("FAIL late_done_at got=%0d want=8", dseen); end
    n_checks++; if (k != 10) begin n_fail++; $display("FAIL late_ack_at got=%0d want=10", k); end
    n_checks++; if (ack_a !== 4'b0100) begin n_fail++; $display("FAIL late_ack got=%b want=0100", ack_a); end
    n_checks++; if (srd_a !== 8'hE7) begin n_fail++; $display("FAIL late_data got=%h want=e7", srd_a); end
    req_a = 4'd0;
    wait_idle_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL late_settle got=busy want=idle"); end
  endtask

  initial begin
    rst = 1'b1; req_a = 4'd0; req_b = 4'd0;
    data_a = 32'd0; data_b = 32'd0; rdy_b = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_pair_0110();
    test_timeout();
    test_reset_mid();
    test_late_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

endmodule
